// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared state encodings and latency helper for the PE array controller
package pe_ctrl_pkg;

  // Controller state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_W  = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Cycles from an activation entering the left edge to its result leaving the bottom
  function automatic int unsigned lat_f(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/ctrl_valid_pipe.sv
// rtl/ctrl_valid_pipe.sv - shift register of {valid, last} tags tracking vectors in flight
module ctrl_valid_pipe #(
  parameter int depth = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [depth-1:0] valid_sr;
  logic [depth-1:0] last_sr;
  logic [depth:0]   valid_next;
  logic [depth:0]   last_next;

  // New tag enters at bit 0; the oldest entry sits at the top bit
  always_comb begin
    valid_next = {valid_sr, in_valid};
    last_next  = {last_sr, in_last};
  end

  // Shift only while the array is computing so tags stay aligned with data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (adv) begin
      valid_sr <= valid_next[depth-1:0];
      last_sr  <= last_next[depth-1:0];
    end
  end

  assign out_valid = valid_sr[depth-1];
  assign out_last  = last_sr[depth-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - sequencing controller for the weight-stationary systolic PE array
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int data_width         = 22,
  parameter int w_tile_row_size    = 11,
  parameter int w_tile_column_size = 11,
  parameter int cnt_width          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 reuse_weights,
  input  logic [cnt_width-1:0] vec_count,
  output logic                 busy,
  output logic                 done,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 act_valid,
  output logic                 act_ready,
  output logic                 pe_w_en,
  output logic                 pe_w_compute,
  output logic                 act_bubble,
  output logic                 res_valid,
  output logic                 res_last
);

  localparam int lat = int'(lat_f(w_tile_row_size, w_tile_column_size));
  localparam int rcw = $clog2(w_tile_row_size + 1);
  localparam logic [rcw-1:0] last_row = rcw'(w_tile_row_size - 1);

  // Degenerate geometries cannot form an array
  if (data_width < 1 || w_tile_row_size < 1 || w_tile_column_size < 1 || cnt_width < 1)
  begin : g_bad_params
    $error("pe_array_ctrl: all size parameters must be at least 1");
  end

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [rcw-1:0]       wrow_cnt;
  logic [cnt_width-1:0] vec_cnt;
  logic [cnt_width-1:0] vec_count_q;
  logic [cnt_width-1:0] last_vec_idx;
  logic                 wts_loaded;
  logic                 vc_zero;
  logic                 w_beat;
  logic                 a_beat;
  logic                 last_w_beat;
  logic                 last_a_beat;
  logic                 pipe_valid;
  logic                 pipe_last;

  // Beat qualifiers; the vector counter is compared against count-1 so it never wraps
  always_comb begin
    vc_zero      = (vec_count_q == '0);
    last_vec_idx = vec_count_q - 1'b1;
    w_beat       = w_ready & w_valid;
    a_beat       = act_ready & act_valid;
    last_w_beat  = w_beat & (wrow_cnt == last_row);
    last_a_beat  = a_beat & (vec_cnt == last_vec_idx);
  end

  // Moore decodes of the registered state (pe_w_en is qualified by the incoming beat)
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    w_ready      = (state_q == ST_LOAD_W);
    act_ready    = (state_q == ST_COMPUTE) & ~vc_zero;
    pe_w_en      = w_beat;
    pe_w_compute = (state_q == ST_COMPUTE) | (state_q == ST_DRAIN);
    act_bubble   = ((state_q == ST_COMPUTE) & ~a_beat) | (state_q == ST_DRAIN);
    res_valid    = pipe_valid & pe_w_compute;
    res_last     = pipe_last & pe_w_compute;
  end

  // Next-state logic for the job sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (reuse_weights && wts_loaded) ? ST_COMPUTE : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (last_w_beat) begin
          state_d = vc_zero ? ST_DONE : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (vc_zero) begin
          state_d = ST_DONE;
        end else if (last_a_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, job parameter latch and the resident-weights flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_count_q <= '0;
      wts_loaded  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        vec_count_q <= vec_count;
      end
      if (last_w_beat) begin
        wts_loaded <= 1'b1;
      end
    end
  end

  // Weight row and activation vector counters, rearmed while idle
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE) begin
      wrow_cnt <= '0;
      vec_cnt  <= '0;
    end else begin
      if (last_w_beat) begin
        wrow_cnt <= '0;
      end else if (w_beat) begin
        wrow_cnt <= wrow_cnt + 1'b1;
      end
      if (a_beat && !last_a_beat) begin
        vec_cnt <= vec_cnt + 1'b1;
      end
    end
  end

  ctrl_valid_pipe #(
    .depth(lat)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .adv      (pe_w_compute),
    .in_valid (a_beat),
    .in_last  (last_a_beat),
    .out_valid(pipe_valid),
    .out_last (pipe_last)
  );

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed self-checking bench for pe_array_ctrl
module tb_pe_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        reuse_weights;
  logic [15:0] vec_count;
  logic        busy;
  logic        done;
  logic        w_valid;
  logic        w_ready;
  logic        act_valid;
  logic        act_ready;
  logic        pe_w_en;
  logic        pe_w_compute;
  logic        act_bubble;
  logic        res_valid;
  logic        res_last;

  int n_checks = 0;
  int n_errors = 0;

  int cyc;
  int n_wen, n_wrdy, n_res, n_last, n_done, n_act;
  int first_res, last_res, res_last_at, done_at, first_act;
  logic res_log [0:511];
  logic bub_log [0:511];

  always #5 clk = ~clk;

  pe_array_ctrl #(
    .data_width        (22),
    .w_tile_row_size   (11),
    .w_tile_column_size(11),
    .cnt_width         (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .reuse_weights(reuse_weights),
    .vec_count    (vec_count),
    .busy         (busy),
    .done         (done),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .pe_w_en      (pe_w_en),
    .pe_w_compute (pe_w_compute),
    .act_bubble   (act_bubble),
    .res_valid    (res_valid),
    .res_last     (res_last)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_wen = 0; n_wrdy = 0; n_res = 0; n_last = 0; n_done = 0; n_act = 0;
    first_res = -1; last_res = -1; res_last_at = -1; done_at = -1; first_act = -1;
    for (int i = 0; i < 512; i++) begin
      res_log[i] = 1'b0;
      bub_log[i] = 1'b0;
    end
  endtask

  // One clock cycle with the given inputs; outputs sampled at the falling edge
  task automatic run_cycle(input logic s, input logic wv, input logic av);
    start = s; w_valid = wv; act_valid = av;
    @(negedge clk);
    if (pe_w_en) n_wen++;
    if (w_ready) n_wrdy++;
    if (act_valid && act_ready) begin
      n_act++;
      if (first_act < 0) first_act = cyc;
    end
    if (res_valid) begin
      n_res++;
      if (first_res < 0) first_res = cyc;
      last_res = cyc;
      if (cyc < 512) res_log[cyc] = 1'b1;
    end
    if (act_bubble && cyc < 512) bub_log[cyc] = 1'b1;
    if (res_last) begin
      n_last++;
      res_last_at = cyc;
    end
    if (done) begin
      n_done++;
      done_at = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: inputs held high; 1: weight stalls and activation gap; 2: stray start pulses
  task automatic wait_done(input int mode);
    int   guard;
    logic wv;
    logic av;
    logic s;
    guard = 0;
    while (n_done == 0 && guard < 400) begin
      wv = 1'b1; av = 1'b1; s = 1'b0;
      if (mode == 1) begin
        wv = (cyc % 2 == 1);
        av = !(cyc >= 24 && cyc <= 26);
      end
      if (mode == 2) s = (cyc == 2 || cyc == 15);
      run_cycle(s, wv, av);
      guard++;
    end
    if (n_done == 0) check("done_timeout", 0, 1);
  endtask

  task automatic start_job(input int vc, input logic reuse, input logic wv);
    clr_stats();
    vec_count = 16'(vc);
    reuse_weights = reuse;
    run_cycle(1'b1, wv, 1'b1);
  endtask

  function automatic int outs_word();
    return int'({busy, done, w_ready, act_ready, pe_w_en, pe_w_compute,
                 act_bubble, res_valid, res_last});
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; reuse_weights = 1'b0; vec_count = '0;
    w_valid = 1'b0; act_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", outs_word(), 0);

    // Normal job
    start_job(4, 1'b0, 1'b1);
    check("t1_busy_rise", int'(busy), 1);
    wait_done(0);
    check("t1_wen_beats", n_wen, 11);
    check("t1_wready_cycles", n_wrdy, 11);
    check("t1_first_act", first_act, 12);
    check("t1_act_beats", n_act, 4);
    check("t1_first_res", first_res, 33);
    check("t1_res_count", n_res, 4);
    check("t1_last_res", last_res, 36);
    check("t1_res_last_at", res_last_at, 36);
    check("t1_res_last_cnt", n_last, 1);
    check("t1_done_at", done_at, 37);
    check("t1_idle_after", int'(busy), 0);

    // Stalls on both buffers
    start_job(4, 1'b0, 1'b0);
    wait_done(1);
    check("t2_wen_beats", n_wen, 11);
    check("t2_bub_23", int'(bub_log[23]), 0);
    check("t2_bub_24", int'(bub_log[24]), 1);
    check("t2_bub_25", int'(bub_log[25]), 1);
    check("t2_bub_26", int'(bub_log[26]), 1);
    check("t2_bub_27", int'(bub_log[27]), 0);
    check("t2_res_44", int'(res_log[44]), 1);
    check("t2_res_45", int'(res_log[45]), 0);
    check("t2_res_47", int'(res_log[47]), 0);
    check("t2_res_48", int'(res_log[48]), 1);
    check("t2_res_count", n_res, 4);
    check("t2_res_last_at", res_last_at, 49);
    check("t2_done_at", done_at, 50);

    // Weight reuse, then reload after reset
    start_job(2, 1'b1, 1'b1);
    wait_done(0);
    check("t3_reuse_wready", n_wrdy, 0);
    check("t3_reuse_first_res", first_res, 22);
    check("t3_reuse_res_count", n_res, 2);
    check("t3_reuse_done_at", done_at, 24);
    rst = 1'b1;
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    start_job(2, 1'b1, 1'b1);
    wait_done(0);
    check("t3_reload_wen", n_wen, 11);
    check("t3_reload_done_at", done_at, 35);

    // Zero vectors
    start_job(0, 1'b0, 1'b1);
    wait_done(0);
    check("t4_zero_wen", n_wen, 11);
    check("t4_zero_res", n_res, 0);
    check("t4_zero_done_at", done_at, 12);
    start_job(0, 1'b1, 1'b1);
    wait_done(0);
    check("t4_zero_reuse_wrdy", n_wrdy, 0);
    check("t4_zero_reuse_res", n_res, 0);
    check("t4_zero_reuse_done_at", done_at, 2);

    // Reset during DRAIN with five vectors in flight
    start_job(5, 1'b1, 1'b1);
    while (cyc < 10) run_cycle(1'b0, 1'b1, 1'b1);
    check("t5_in_drain", int'(act_bubble & pe_w_compute & ~act_ready), 1);
    check("t5_in_flight", n_act, 5);
    rst = 1'b1;
    run_cycle(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    check("t5_outputs_after_rst", outs_word(), 0);
    clr_stats();
    repeat (40) run_cycle(1'b0, 1'b1, 1'b1);
    check("t5_no_res_after_rst", n_res, 0);
    check("t5_no_done_after_rst", n_done, 0);
    start_job(1, 1'b1, 1'b1);
    wait_done(0);
    check("t5_reload_wen", n_wen, 11);
    check("t5_reload_done_at", done_at, 34);

    // Start pulses while busy are ignored
    start_job(3, 1'b1, 1'b1);
    vec_count = 16'd9;
    reuse_weights = 1'b0;
    wait_done(2);
    check("t6_res_count", n_res, 3);
    check("t6_done_at", done_at, 25);
    repeat (3) run_cycle(1'b0, 1'b1, 1'b1);
    check("t6_single_done", n_done, 1);
    check("t6_idle_after", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
